// File: rtl/median5x5_ctrl_if.sv
// AXI4-Stream sideband bundle (no data lane) shared by the input and output sides of the
// 5x5 median filter control block.
//   tvalid : beat valid            (master -> slave)
//   tuser  : start of frame        (master -> slave)
//   tlast  : end of line           (master -> slave)
//   tready : beat accept           (slave  -> master)
interface median5x5_ctrl_if;
  logic tvalid;
  logic tuser;
  logic tlast;
  logic tready;

  modport master (output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/median5x5_ctrl.sv
// Control and sequencing for the 5x5 median filter datapath.
// Tracks pixel/line position of the incoming video stream, drives the line-buffer write and
// window-shift controls, checks framing, and produces the output stream sideband aligned to
// the PIPE_LAT-deep datapath pipeline.
// Ports:
//   clk, aresetn       : clock, synchronous active-low reset
//   s_axis (slave)     : input stream sideband; tready = pipe_ce
//   m_axis (master)    : output stream sideband, (WIDTH-4)x(HEIGHT-4) valid windows
//   pipe_ce            : global datapath clock enable
//   lb_wr_en/row/col   : line buffer write strobe and address; lb_wr_row is also the oldest row
//   win_shift          : shift the 5x5 window by one column
//   err_*, frame_done  : one-cycle pulses, registered one cycle after the causing beat
module median5x5_ctrl #(
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned HEIGHT   = 10,
  parameter int unsigned PIPE_LAT = 3
) (
  input  logic                     clk,
  input  logic                     aresetn,
  median5x5_ctrl_if.slave          s_axis,
  median5x5_ctrl_if.master         m_axis,
  output logic                     pipe_ce,
  output logic                     lb_wr_en,
  output logic [2:0]               lb_wr_row,
  output logic [$clog2(WIDTH)-1:0] lb_wr_col,
  output logic                     win_shift,
  output logic                     err_early_tlast,
  output logic                     err_missing_tlast,
  output logic                     err_sof_midframe,
  output logic                     frame_done
);
  localparam int unsigned ColW = $clog2(WIDTH);
  localparam int unsigned RowW = $clog2(HEIGHT);
  localparam logic [ColW-1:0] ColLast  = ColW'(WIDTH - 1);
  localparam logic [RowW-1:0] RowLast  = RowW'(HEIGHT - 1);
  localparam logic [ColW-1:0] ColFirst = ColW'(4);
  localparam logic [RowW-1:0] RowFirst = RowW'(4);

  typedef enum logic [1:0] {StIdle, StActive, StResync} state_e;

  state_e          state_q, state_d;
  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic [2:0]      lbrow_q, lbrow_d;
  logic            early_q, early_d;
  logic            missing_q, missing_d;
  logic            sof_mid_q, sof_mid_d;
  logic            done_q, done_d;

  // Output sideband pipeline; index PIPE_LAT-1 is the stage presented on m_axis.
  logic [PIPE_LAT-1:0] vld_q, usr_q, lst_q;

  logic            acc, sof, take, col_last, early;
  logic [ColW-1:0] cur_col;
  logic [RowW-1:0] cur_row;
  logic [2:0]      cur_lbrow;
  logic            out_v, out_u, out_l;

  assign pipe_ce       = aresetn & (~vld_q[PIPE_LAT-1] | m_axis.tready);
  assign s_axis.tready = pipe_ce;

  assign acc  = s_axis.tvalid & pipe_ce;
  // Any accepted tuser beat is pixel (0,0), whatever the state.
  assign sof  = acc & s_axis.tuser;
  assign take = sof | (acc & (state_q == StActive));

  assign cur_col   = sof ? '0 : col_q;
  assign cur_row   = sof ? '0 : row_q;
  assign cur_lbrow = sof ? 3'd0 : lbrow_q;
  assign col_last  = (cur_col == ColLast);
  // tuser wins over tlast, so a SOF beat never flags early tlast.
  assign early     = take & ~sof & s_axis.tlast & ~col_last;

  // State register
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q   <= StIdle;
      col_q     <= '0;
      row_q     <= '0;
      lbrow_q   <= 3'd0;
      early_q   <= 1'b0;
      missing_q <= 1'b0;
      sof_mid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      lbrow_q   <= lbrow_d;
      early_q   <= early_d;
      missing_q <= missing_d;
      sof_mid_q <= sof_mid_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    lbrow_d   = lbrow_q;
    early_d   = 1'b0;
    missing_d = 1'b0;
    sof_mid_d = 1'b0;
    done_d    = 1'b0;
    if (take) begin
      if (early) begin
        state_d = StResync;
        col_d   = '0;
        row_d   = '0;
        lbrow_d = 3'd0;
        early_d = 1'b1;
      end else begin
        state_d   = StActive;
        sof_mid_d = sof & (state_q == StActive);
        missing_d = col_last & ~s_axis.tlast;
        if (col_last) begin
          col_d = '0;
          if (cur_row == RowLast) begin
            state_d = StIdle;
            row_d   = '0;
            lbrow_d = 3'd0;
            done_d  = 1'b1;
          end else begin
            row_d   = cur_row + RowW'(1);
            lbrow_d = (cur_lbrow == 3'd4) ? 3'd0 : cur_lbrow + 3'd1;
          end
        end else begin
          col_d   = cur_col + ColW'(1);
          row_d   = cur_row;
          lbrow_d = cur_lbrow;
        end
      end
    end
  end

  // Outputs to the datapath and the sideband entering the pipeline
  always_comb begin
    lb_wr_en  = take;
    win_shift = take;
    lb_wr_col = cur_col;
    lb_wr_row = cur_lbrow;
    // An abandoned beat produces no output; only full 5x5 windows do.
    out_v     = take & ~early & (cur_row >= RowFirst) & (cur_col >= ColFirst);
    out_u     = out_v & (cur_row == RowFirst) & (cur_col == ColFirst);
    out_l     = out_v & col_last;
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      vld_q <= '0;
      usr_q <= '0;
      lst_q <= '0;
    end else if (pipe_ce) begin
      vld_q[0] <= out_v;
      usr_q[0] <= out_u;
      lst_q[0] <= out_l;
      for (int i = 1; i < PIPE_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        usr_q[i] <= usr_q[i-1];
        lst_q[i] <= lst_q[i-1];
      end
    end
  end

  assign m_axis.tvalid     = vld_q[PIPE_LAT-1];
  assign m_axis.tuser      = usr_q[PIPE_LAT-1];
  assign m_axis.tlast      = lst_q[PIPE_LAT-1];
  assign err_early_tlast   = early_q;
  assign err_missing_tlast = missing_q;
  assign err_sof_midframe  = sof_mid_q;
  assign frame_done        = done_q;
endmodule

// File: tb/tb_median5x5_ctrl.sv
// Bench for median5x5_ctrl: directed frames with a cycle-level behavioural model and
// per-test literal counts of output beats, sideband and pulses.
module tb_median5x5_ctrl;
  localparam int W  = 10;
  localparam int H  = 10;
  localparam int PL = 3;

  logic       clk = 1'b0;
  logic       aresetn;
  logic       pipe_ce, lb_wr_en, win_shift;
  logic [2:0] lb_wr_row;
  logic [3:0] lb_wr_col;
  logic       err_early_tlast, err_missing_tlast, err_sof_midframe, frame_done;

  median5x5_ctrl_if s_if ();
  median5x5_ctrl_if m_if ();

  median5x5_ctrl #(.WIDTH(W), .HEIGHT(H), .PIPE_LAT(PL)) dut (
    .clk               (clk),
    .aresetn           (aresetn),
    .s_axis            (s_if),
    .m_axis            (m_if),
    .pipe_ce           (pipe_ce),
    .lb_wr_en          (lb_wr_en),
    .lb_wr_row         (lb_wr_row),
    .lb_wr_col         (lb_wr_col),
    .win_shift         (win_shift),
    .err_early_tlast   (err_early_tlast),
    .err_missing_tlast (err_missing_tlast),
    .err_sof_midframe  (err_sof_midframe),
    .frame_done        (frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit rdy_rand = 1'b0;

  // Per-test observations of the DUT
  int out_beats, out_users, out_lasts, last_misplaced, n_done, n_early, n_miss, n_sofm;
  int first_tuser_cyc;
  int last_acc, frame_first, frame_last, acc44;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic clr();
    out_beats = 0; out_users = 0; out_lasts = 0; last_misplaced = 0;
    n_done = 0; n_early = 0; n_miss = 0; n_sofm = 0; first_tuser_cyc = -1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    m_if.tready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Behavioural model and compare process
  initial begin
    int md;  // 0 idle, 1 in frame, 2 waiting for resync
    int pr, pc, r, c;
    bit [2:0] pipe[$];
    bit p_early, p_miss, p_sofm, p_done;
    bit n_e, n_m, n_s, n_d;
    bit rn, iv, iu, il, mr, exp_mv, exp_ce, acc, sof, take, v;
    bit [2:0] ent;
    md = 0; pr = 0; pc = 0;
    p_early = 0; p_miss = 0; p_sofm = 0; p_done = 0;
    for (int i = 0; i < PL; i++) pipe.push_back(3'b000);
    forever begin
      @(negedge clk);
      rn = aresetn; iv = s_if.tvalid; iu = s_if.tuser; il = s_if.tlast; mr = m_if.tready;
      exp_mv = pipe[0][2];
      exp_ce = rn && (!exp_mv || mr);
      acc    = iv && exp_ce;
      sof    = acc && iu;
      take   = sof || (acc && md == 1);
      r      = sof ? 0 : pr;
      c      = sof ? 0 : pc;

      chk("pipe_ce", pipe_ce, exp_ce);
      chk("s_tready", s_if.tready, exp_ce);
      chk("m_tvalid", m_if.tvalid, exp_mv);
      if (exp_mv) begin
        chk("m_tuser", m_if.tuser, pipe[0][1]);
        chk("m_tlast", m_if.tlast, pipe[0][0]);
      end
      chk("lb_wr_en", lb_wr_en, take);
      chk("win_shift", win_shift, take);
      if (take) begin
        chk("lb_wr_col", lb_wr_col, c);
        chk("lb_wr_row", lb_wr_row, r % 5);
      end
      chk("err_early", err_early_tlast, p_early);
      chk("err_missing", err_missing_tlast, p_miss);
      chk("err_sofmid", err_sof_midframe, p_sofm);
      chk("frame_done", frame_done, p_done);

      if (m_if.tvalid && m_if.tready) begin
        out_beats++;
        if (m_if.tuser) begin
          out_users++;
          if (first_tuser_cyc < 0) first_tuser_cyc = cyc;
        end
        if (m_if.tlast) begin
          out_lasts++;
          if (out_beats % (W - 4) != 0) last_misplaced++;
        end
      end
      if (frame_done) n_done++;
      if (err_early_tlast) n_early++;
      if (err_missing_tlast) n_miss++;
      if (err_sof_midframe) n_sofm++;

      n_e = 0; n_m = 0; n_s = 0; n_d = 0;
      if (!rn) begin
        md = 0; pr = 0; pc = 0;
        for (int i = 0; i < PL; i++) pipe[i] = 3'b000;
      end else begin
        ent = 3'b000;
        if (take) begin
          if (!sof && il && c < W - 1) begin
            n_e = 1; md = 2; pr = 0; pc = 0;
          end else begin
            n_s = sof && md == 1;
            n_m = (c == W - 1) && !il;
            v   = (r >= 4) && (c >= 4);
            ent = {v, v && r == 4 && c == 4, v && c == W - 1};
            md  = 1;
            if (c == W - 1) begin
              pc = 0;
              if (r == H - 1) begin
                n_d = 1; md = 0; pr = 0;
              end else begin
                pr = r + 1;
              end
            end else begin
              pc = c + 1; pr = r;
            end
          end
        end
        if (exp_ce) begin
          void'(pipe.pop_front());
          pipe.push_back(ent);
        end
      end
      p_early = n_e; p_miss = n_m; p_sofm = n_s; p_done = n_d;
    end
  end

  // Present one beat (after gap idle cycles) and hold it until accepted.
  task automatic send_px(input bit u, input bit l, input int gap);
    bit done;
    repeat (gap) begin
      s_if.tvalid = 1'b0;
      @(posedge clk); #1;
    end
    s_if.tvalid = 1'b1; s_if.tuser = u; s_if.tlast = l;
    done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (s_if.tready) begin
        done = 1;
        last_acc = cyc;
      end
      @(posedge clk); #1;
    end
    if (!done) chk("accept_timeout", 0, 1);
    s_if.tvalid = 1'b0;
  endtask

  // Raster frame; tlast dropped on row miss_r, stops before (stop_r, stop_c) if stop_r >= 0.
  task automatic send_frame(input int gapmax, input int miss_r, input int stop_r, input int stop_c);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == stop_r && c == stop_c) return;
        send_px(r == 0 && c == 0, c == W - 1 && r != miss_r, $urandom_range(0, gapmax));
        if (r == 0 && c == 0) frame_first = last_acc;
        if (r == 4 && c == 4) acc44 = last_acc;
        frame_last = last_acc;
      end
    end
  endtask

  task automatic drain();
    rdy_rand = 1'b0;
    s_if.tvalid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic expect_counts(input string t, input int beats, input int users, input int lasts,
                               input int done, input int early, input int miss, input int sofm);
    chk({t, "_beats"}, out_beats, beats);
    chk({t, "_tuser"}, out_users, users);
    chk({t, "_tlast"}, out_lasts, lasts);
    chk({t, "_tlast_pos"}, last_misplaced, 0);
    chk({t, "_done"}, n_done, done);
    chk({t, "_early"}, n_early, early);
    chk({t, "_missing"}, n_miss, miss);
    chk({t, "_sofmid"}, n_sofm, sofm);
  endtask

  initial begin
    int f1_last, f1_acc44;
    #1000000;
    $display("FAIL watchdog at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int f1_last, f1_acc44;
    aresetn = 1'b0;
    s_if.tvalid = 1'b0; s_if.tuser = 1'b0; s_if.tlast = 1'b0;
    clr();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pipe_ce", pipe_ce, 0);
    chk("rst_s_tready", s_if.tready, 0);
    chk("rst_m_tvalid", m_if.tvalid, 0);
    chk("rst_frame_done", frame_done, 0);
    @(posedge clk); #1;
    aresetn = 1'b1;

    // Two back-to-back continuous frames
    clr();
    send_frame(0, -1, -1, -1);
    f1_last = frame_last; f1_acc44 = acc44;
    send_frame(0, -1, -1, -1);
    chk("b2b_no_bubble", frame_first, f1_last + 1);
    chk("first_tuser_latency", first_tuser_cyc - f1_acc44, 3);
    drain();
    expect_counts("t1", 72, 2, 12, 2, 0, 0, 0);

    // Input gaps and random downstream stalls
    clr();
    rdy_rand = 1'b1;
    send_frame(2, -1, -1, -1);
    drain();
    expect_counts("t2", 36, 1, 6, 1, 0, 0, 0);

    // Early tlast at (0,2), junk discarded, then a clean frame
    clr();
    send_px(1, 0, 0);
    send_px(0, 0, 0);
    send_px(0, 1, 0);
    for (int i = 0; i < 3; i++) send_px(0, i[0], 1);
    drain();
    chk("t3_no_output", out_beats, 0);
    send_frame(0, -1, -1, -1);
    drain();
    expect_counts("t3", 36, 1, 6, 1, 1, 0, 0);

    // Missing tlast at end of line 0
    clr();
    send_frame(0, 0, -1, -1);
    drain();
    expect_counts("t4", 36, 1, 6, 1, 0, 1, 0);

    // Mid-frame tuser at (3,5) restarts the frame
    clr();
    send_frame(0, -1, 3, 5);
    send_frame(0, -1, -1, -1);
    drain();
    expect_counts("t5", 36, 1, 6, 1, 0, 0, 1);

    // One-cycle reset while pixel (6,6) is offered
    clr();
    send_frame(0, -1, 6, 6);
    s_if.tvalid = 1'b1; s_if.tuser = 1'b0; s_if.tlast = 1'b0;
    aresetn = 1'b0;
    @(posedge clk); #1;
    aresetn = 1'b1;
    s_if.tvalid = 1'b0;
    @(negedge clk);
    chk("t6_m_tvalid_cleared", m_if.tvalid, 0);
    @(posedge clk); #1;
    clr();
    send_frame(0, -1, -1, -1);
    drain();
    expect_counts("t6", 36, 1, 6, 1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/median5x5_ctrl.md
# median5x5_ctrl

Control and sequencing block for the 5x5 median filter datapath. It consumes the sideband of the incoming AXI4-Stream video (tvalid/tuser/tlast) and tracks pixel/line position. It drives the write/rotate controls of the 4-line buffer and the window shift register. It also generates the output stream sideband (tvalid/tuser/tlast), aligned to the datapath pipeline. It sits between the video source and the median datapath and owns framing checks and recovery.

## Interface
- `WIDTH`, 10, active pixels per line (≥5)
- `HEIGHT`, 10, lines per frame (≥5)
- `PIPE_LAT`, 3, datapath latency in enabled cycles from accepted input beat to median result (≥1)
- `clk`  in  1  single clock, all logic on rising edge
- `aresetn`  in  1  **synchronous, active-low reset**
- `s_axis_tvalid`  in  1  input beat valid
- `s_axis_tuser`  in  1  start of frame
- `s_axis_tlast`  in  1  end of line
- `s_axis_tready`  out  1  input accept
- `m_axis_tready`  in  1  downstream accept
- `m_axis_tvalid`  out  1  output beat valid
- `m_axis_tuser`  out  1  output start of frame
- `m_axis_tlast`  out  1  output end of line
- `pipe_ce`  out  1  global datapath clock enable
- `lb_wr_en`  out  1  write current pixel into line buffer
- `lb_wr_row`  out  3  line buffer row being written, 0..4
- `lb_wr_col`  out  $clog2(WIDTH)  column address
- `win_shift`  out  1  shift the 5x5 window one column
- `err_early_tlast`  out  1  one-cycle pulse
- `err_missing_tlast`  out  1  one-cycle pulse
- `err_sof_midframe`  out  1  one-cycle pulse
- `frame_done`  out  1  one-cycle pulse on last pixel of a frame

## Operation
- `pipe_ce` = ~m_axis_tvalid | m_axis_tready; forced 0 while aresetn=0. `s_axis_tready` = `pipe_ce`.
- Accepted beat `acc` = s_axis_tvalid & s_axis_tready. tvalid gaps simply stall counters.
- Counters: `col` 0..WIDTH-1, `row` 0..HEIGHT-1, `lb_wr_row` 0..4 (mod 5).
- FSM states: IDLE, ACTIVE, RESYNC.
  - IDLE: accept and discard beats with tuser=0. On acc with tuser=1, this beat is pixel (0,0): go to ACTIVE.
  - ACTIVE: on each acc, col++. At col=WIDTH-1: col←0, row++, lb_wr_row←(lb_wr_row+1) mod 5. At row=HEIGHT-1 and col=WIDTH-1: frame_done pulse, go to IDLE.
  - RESYNC: discard beats until acc with tuser=1, then treat as IDLE→ACTIVE on that beat.
- Framing errors, all in ACTIVE on acc:
  - tlast=1 with col<WIDTH-1: err_early_tlast, go to RESYNC. The frame is abandoned and no further output beats are produced for it.
  - tlast=0 at col=WIDTH-1: err_missing_tlast, continue as if tlast were present.
  - tuser=1 at any position other than (0,0): err_sof_midframe, restart at (0,0) with this beat and reset lb_wr_row to 0. The output frame restarts.
- Datapath control, combinational on acc in ACTIVE (or the SOF beat):
  - lb_wr_en=1, win_shift=1, lb_wr_col=col.
  - lb_wr_row also identifies the oldest buffered row for the read mux.
- Output: output frame is (WIDTH-4)x(HEIGHT-4), valid windows only.
  - A beat generates an output beat when row≥4 and col≥4.
  - tuser=1 when (row,col)=(4,4).
  - tlast=1 when col=WIDTH-1.
  - These three bits enter a PIPE_LAT-stage shift register advanced only when pipe_ce=1. Bubbles enter as valid=0.
  - m_axis_* = final stage.

## Timing
- Reset (aresetn=0 at a rising edge): state=IDLE; col, row, lb_wr_row=0; shift register cleared.
  - m_axis_tvalid/tuser/tlast=0.
  - All error pulses and frame_done=0.
  - s_axis_tready=0, pipe_ce=0.
- Reset mid-frame discards all partial state. The next frame requires a fresh tuser.
- Latency: m_axis_tvalid rises exactly PIPE_LAT pipe_ce-enabled cycles after the acc of input pixel (4,4).
- With m_axis_tready held low and m_axis_tvalid=1, everything freezes: counters, shift register, s_axis_tready=0. m_axis_* stays stable (AXIS rule).
- Error pulses and frame_done are asserted the cycle after the offending/final acc, for exactly one cycle.
- Simultaneous tuser and tlast on one beat in ACTIVE: the tuser rule takes priority. The beat is pixel (0,0); no early-tlast error is raised unless WIDTH=1 (not allowed).
- Back-to-back frames: a tuser beat in the cycle after frame_done is accepted with no bubble.

## Test plan
- WIDTH=HEIGHT=10, PIPE_LAT=3, continuous 100-beat frame, m_axis_tready=1 -> 36 output beats. m_axis_tuser on the first (3 cycles after input beat 44); tlast on beats 6,12,…,36; frame_done once.
- Same frame with random tvalid gaps and random m_axis_tready -> identical 36-beat sequence and sideband; no beat lost or duplicated.
- Early tlast at line 0, col 2 -> err_early_tlast pulse, no output. Next frame with tuser is processed normally (36 beats).
- tlast missing at line 0, col 9 -> err_missing_tlast pulse, frame completes, 36 output beats, correct tlast on output.
- tuser asserted at pixel (3,5) -> err_sof_midframe. The counter restarts and lb_wr_row=0, then the full frame from that beat yields 36 beats.
- aresetn low for 1 cycle at pixel (6,6), then a new frame -> outputs cleared next cycle. The new frame yields exactly 36 beats with a single tuser.
